// File: rtl/shift_logic_unit.sv
// Shift/logic unit: bitwise ops plus shifts/rotates done iteratively one bit per cycle.
// Define SHIFT_LOGIC_UNIT_BARREL_EN to finish every shift/rotate in a single step.
//
// state | meaning
// IDLE  | waiting for start; captures op/in1/in2
// SHIFT | one-bit shift/rotate per cycle while count runs down
// DONE  | out valid, done pulse, return to IDLE
module shift_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step;

`ifdef SHIFT_LOGIC_UNIT_BARREL_EN
    function automatic logic [WIDTH-1:0] result_full(input logic [3:0] o,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] dbl;
        logic [LW-1:0]      r;
        r   = b[LW-1:0];
        dbl = '0;
        case (o)
            4'd0:       return a & b;
            4'd1:       return a | b;
            4'd2:       return a ^ b;
            4'd3:       return $unsigned($signed(a) >>> b);
            4'd4, 4'd6: return a << b;
            4'd5:       return a >> b;
            4'd7:       return ~a;
            4'd8: begin
                dbl = {a, a} >> r;
                return dbl[WIDTH-1:0];
            end
            4'd9: begin
                dbl = {a, a} << r;
                return dbl[2*WIDTH-1:WIDTH];
            end
            default:    return '0;
        endcase
    endfunction
`else
    function automatic logic [CW-1:0] shift_count(input logic [3:0] o,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            4'd3, 4'd4, 4'd5, 4'd6:
                return (b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : b[CW-1:0];
            4'd8, 4'd9: return {1'b0, b[LW-1:0]};
            default:    return '0;
        endcase
    endfunction

    // Result when no shifting is needed; zero-count shifts/rotates pass in1 through.
    function automatic logic [WIDTH-1:0] result_no_shift(input logic [3:0] o,
                                                         input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        case (o)
            4'd0:                                return a & b;
            4'd1:                                return a | b;
            4'd2:                                return a ^ b;
            4'd7:                                return ~a;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: return a;
            default:                             return '0;
        endcase
    endfunction

    logic [CW-1:0] k_cap;
    assign k_cap = shift_count(op, in2);
`endif

    always_comb begin
        case (op_q)
            4'd3:       step = {sign_q, work_q[WIDTH-1:1]};
            4'd4, 4'd6: step = {work_q[WIDTH-2:0], 1'b0};
            4'd5:       step = {1'b0, work_q[WIDTH-1:1]};
            4'd8:       step = {work_q[0], work_q[WIDTH-1:1]};
            4'd9:       step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default:    step = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    work_d = in1;
                    sign_d = in1[WIDTH-1];
`ifdef SHIFT_LOGIC_UNIT_BARREL_EN
                    cnt_d   = '0;
                    out_d   = result_full(op, in1, in2);
                    state_d = DONE;
`else
                    cnt_d = k_cap;
                    if (k_cap != '0) begin
                        state_d = SHIFT;
                    end else begin
                        out_d   = result_no_shift(op, in1, in2);
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    out_d   = step;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            work_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: doc/shift_logic_unit.md
SHIFT_LOGIC_UNIT -- requirements
Module: shift_logic_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width; legal values are powers of two, 4 to 64.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: request a new operation.
REQ-006 Port op, input, 4 bits: operation select.
REQ-007 Port in1, input, WIDTH bits: signed operand A.
REQ-008 Port in2, input, WIDTH bits: operand B, or shift amount for shift ops.
REQ-009 Port busy, output, 1 bit: operation in progress.
REQ-010 Port done, output, 1 bit: single-cycle pulse; out valid.
REQ-011 Port out, output, WIDTH bits: registered result.

Function
REQ-012 op encoding SHALL be:
- 0 AND
- 1 OR
- 2 XOR
- 3 arithmetic right shift (ASR)
- 4 arithmetic left shift (ASL, identical to LSL)
- 5 logical right shift (LSR)
- 6 logical left shift (LSL)
- 7 NOT in1
- 8 rotate right (ROR)
- 9 rotate left (ROL)
- 10-15 illegal: result 0.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE SHALL sample start, and SHALL capture op, in1 and in2 on a rising edge with start=1; later input changes SHALL not affect that operation.
REQ-015 The shift count k SHALL be:
- for ops 3-6: min(in2 unsigned, WIDTH);
- for ops 8-9: in2 mod WIDTH;
- otherwise: 0.
REQ-016 On capture, the FSM SHALL go to SHIFT if k>0, else to DONE.
REQ-017 In SHIFT, the working register SHALL shift or rotate by exactly one bit per cycle and decrement k, moving to DONE after the edge where k reaches 0.
- ASR SHALL fill with the captured sign bit.
- LSR, LSL and ASL SHALL fill with 0.
REQ-018 out SHALL be updated on the edge entering DONE; done=1 for exactly the one cycle spent in DONE; DONE SHALL then return to IDLE.
REQ-019 Latency SHALL be: start sampled at edge t -> done high after edge t+1+k (logic ops: t+1).
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored and not queued; the earliest next acceptance is the edge after done.
REQ-022 out SHALL hold its value between done pulses.
REQ-023 Boundary behaviour for shift amounts:
- ASR by >=WIDTH SHALL give all sign bits.
- LSR, LSL or ASL by >=WIDTH SHALL give 0.
- Rotate by a multiple of WIDTH SHALL give in1 unchanged.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, out=0 and clear the count, overriding start.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-026 With macro SHIFT_LOGIC_UNIT_BARREL_EN defined, all shifts and rotates SHALL complete combinationally in one step: SHIFT is never entered, and every op has done after edge t+1.
REQ-027 Without SHIFT_LOGIC_UNIT_BARREL_EN, the iterative behaviour of REQ-016 to REQ-019 SHALL apply.
REQ-028 Results SHALL be identical in both builds; only latency differs.

Verification (WIDTH=8, iterative build unless noted)
REQ-029 AND: in1=0x3C, in2=0x0F, op=0, start -> done after t+1, out=0x0C, busy high for 1 cycle.
REQ-030 ASR: in1=0xC0, in2=3, op=3 -> done after t+4, out=0xF8; ASR with in2=0x20 -> done after t+9, out=0xFF.
REQ-031 Rotates:
- ROR in1=0x81, in2=9 -> k=1, out=0xC0;
- ROL in1=0x81, in2=8 -> done after t+1, out=0x81.
REQ-032 LSR in1=0xF0, in2=4, with a second start pulsed while busy -> exactly one done after t+5, out=0x0F, second start ignored.
REQ-033 Reset mid-op: LSL in1=0x01, in2=6, rst at t+3 -> busy=0, done never pulses, out=0x00; the next op=7 with in1=0x55 -> out=0xAA.
REQ-034 Barrel build: ASR in1=0x80, in2=7 -> done after t+1, out=0xFF; illegal op=12 -> done after t+1, out=0x00.
